// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_STEP     = 4;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH    = 32;

  // One buffered fetch result: the instruction word and the byte PC it came from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_entry_t;

  // Instructions are word aligned, so the two low PC bits are always cleared.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO holding returned instruction words until decode accepts them.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t [1:0] ent_q;
  fetch_entry_t [1:0] ent_d;
  logic [1:0]         count_q;
  logic [1:0]         count_d;
  logic               pop_ok_s;
  logic               push_ok_s;

  // Next-state computation: flush beats push/pop; push/pop are guarded against over/underflow.
  always_comb begin
    ent_d     = ent_q;
    count_d   = count_q;
    pop_ok_s  = pop & (count_q != 2'd0);
    push_ok_s = push & ((count_q != 2'd2) | pop_ok_s);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          ent_d[count_q[0]] = push_entry;
          count_d           = count_q + 2'd1;
        end
        2'b01: begin
          ent_d[0] = ent_q[1];
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent_d[0] = push_entry;
          end else begin
            ent_d[0] = ent_q[1];
            ent_d[1] = push_entry;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Storage and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q   <= '0;
      count_q <= 2'd0;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = ent_q[0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues one word read per cycle to a
// synchronous-read memory, and streams returned words to decode through a
// 2-entry skid buffer. DATA_WIDTH must equal fetch_pkg::INSTR_WIDTH.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [31:0]           out_pc
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] inflight_pc_q;
  logic [PC_WIDTH-1:0] inflight_pc_d;
  logic                inflight_q;
  logic                inflight_d;
  logic [PC_WIDTH-1:0] issue_pc_s;
  logic [PC_WIDTH-1:0] addr_pc_s;
  logic                issue_s;
  logic                pop_s;
  logic                push_s;
  logic [1:0]          count_s;
  logic [1:0]          count_next_s;
  fetch_entry_t        head_s;
  fetch_entry_t        push_entry_s;

  // Issue decision: keep at most two words buffered-or-inflight; a redirect always issues.
  always_comb begin
    pop_s        = (count_s != 2'd0) & out_ready;
    count_next_s = count_s + {1'b0, inflight_q} - {1'b0, pop_s};
    if (rst) begin
      issue_s = 1'b0;
    end else if (redirect_valid) begin
      issue_s = 1'b1;
    end else if (count_next_s <= 2'd1) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    if (redirect_valid) begin
      issue_pc_s = align_pc(redirect_pc);
    end else begin
      issue_pc_s = pc_q;
    end
  end

  // Memory address: the memory reads every cycle, so the address always shows the issue PC.
  always_comb begin
    if (rst) begin
      addr_pc_s = align_pc(RESET_PC);
    end else begin
      addr_pc_s = issue_pc_s;
    end
    imem_address = addr_pc_s[ADDR_WIDTH+1:2];
  end

  // Returned word goes to the buffer unless a redirect discards it.
  always_comb begin
    push_s             = inflight_q & ~redirect_valid & ~rst;
    push_entry_s.instr = imem_data;
    push_entry_s.pc    = inflight_pc_q;
  end

  // Next PC and inflight tracking.
  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    if (issue_s) begin
      inflight_d    = 1'b1;
      inflight_pc_d = issue_pc_s;
      pc_d          = issue_pc_s + PC_WIDTH'(PC_STEP);
    end else begin
      inflight_d = 1'b0;
    end
  end

  // PC and inflight registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= align_pc(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .count      (count_s),
    .head       (head_s)
  );

  assign out_valid = (count_s != 2'd0);
  assign out_instr = head_s.instr;
  assign out_pc    = head_s.pc;

endmodule
